// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface multicycle_controller_if #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned ALUCTL_W = 4
);
    logic [OPCODE_W-1:0] In_Opcode;
    logic [FUNCT_W-1:0]  In_Funct;
    logic                In_Is0;
    logic                In_MemReady;
    logic                RegDst;
    logic                RegWrite;
    logic                ALUSrc;
    logic [ALUCTL_W-1:0] ALUControl;
    logic                MemWrite;
    logic                MemRead;
    logic                MemToReg;
    logic                PCSrc;
    logic                JumpPC;
    logic                PCWrite;
    logic                IRWrite;
    logic                InstrDone;
    logic                IllegalOp;
    logic                BusError;

    modport master (
        input  In_Opcode, In_Funct, In_Is0, In_MemReady,
        output RegDst, RegWrite, ALUSrc, ALUControl, MemWrite, MemRead, MemToReg,
               PCSrc, JumpPC, PCWrite, IRWrite, InstrDone, IllegalOp, BusError
    );

    modport slave (
        output In_Opcode, In_Funct, In_Is0, In_MemReady,
        input  RegDst, RegWrite, ALUSrc, ALUControl, MemWrite, MemRead, MemToReg,
               PCSrc, JumpPC, PCWrite, IRWrite, InstrDone, IllegalOp, BusError
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a shared
// ALU and memory port, variable-latency memory handshake and access timeout.
module multicycle_controller #(
    parameter int unsigned OPCODE_W    = 6,
    parameter int unsigned FUNCT_W     = 6,
    parameter int unsigned ALUCTL_W    = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input logic clk,
    input logic rst_n,
    multicycle_controller_if.master bus
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpJ     = 6'h02;

    localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT);

    typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StMem, StWb, StJump} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [OPCODE_W-1:0] opcode_q;
    logic [FUNCT_W-1:0]  funct_q;
    logic                latch;
    logic                mem_wait, timeout;
    logic [5:0]          in_op6, op6, fn6;
    logic                in_op_hi_ok, fn_hi_ok;
    logic                r_ok;
    logic [3:0]          r_alu;

    function automatic logic [ALUCTL_W-1:0] alu(input logic [3:0] code);
        return ALUCTL_W'(code);
    endfunction

    // Only the low 6 bits are decoded; any set upper bit makes the field illegal.
    assign in_op6      = bus.In_Opcode[5:0];
    assign in_op_hi_ok = (bus.In_Opcode >> 6) == '0;
    assign op6         = opcode_q[5:0];
    assign fn6         = funct_q[5:0];
    assign fn_hi_ok    = (funct_q >> 6) == '0;

    always_comb begin
        r_ok  = 1'b1;
        r_alu = 4'b0000;
        case (fn6)
            6'h20:   r_alu = 4'b0010;
            6'h22:   r_alu = 4'b0110;
            6'h24:   r_alu = 4'b0000;
            6'h25:   r_alu = 4'b0001;
            6'h2A:   r_alu = 4'b0111;
            default: r_ok  = 1'b0;
        endcase
    end

    assign mem_wait = ((state_q == StFetch) || (state_q == StMem)) && !bus.In_MemReady;
    assign timeout  = (MEM_TIMEOUT > 0) && mem_wait && (cnt_q == CntMax);

    always_comb begin
        state_d        = state_q;
        latch          = 1'b0;
        bus.RegDst     = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrc     = 1'b0;
        bus.ALUControl = '0;
        bus.MemWrite   = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemToReg   = 1'b0;
        bus.PCSrc      = 1'b0;
        bus.JumpPC     = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.InstrDone  = 1'b0;
        bus.IllegalOp  = 1'b0;
        bus.BusError   = 1'b0;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                bus.MemRead    = 1'b1;
                bus.ALUControl = alu(4'b0010);
                if (bus.In_MemReady) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    state_d     = StDecode;
                end else if (timeout) begin
                    bus.BusError = 1'b1;
                end
            end
            StDecode: begin
                latch = 1'b1;
                if (in_op_hi_ok && (in_op6 inside {OpRtype, OpLw, OpSw, OpAddi, OpBeq})) begin
                    state_d = StExec;
                end else if (in_op_hi_ok && in_op6 == OpJ) begin
                    state_d = StJump;
                end else begin
                    bus.IllegalOp = 1'b1;
                    state_d       = StFetch;
                end
            end
            StExec: begin
                state_d = StFetch;
                case (op6)
                    OpRtype: begin
                        if (r_ok && fn_hi_ok) begin
                            bus.ALUControl = alu(r_alu);
                            state_d        = StWb;
                        end else begin
                            bus.IllegalOp = 1'b1;
                        end
                    end
                    OpLw, OpSw, OpAddi: begin
                        bus.ALUSrc     = 1'b1;
                        bus.ALUControl = alu(4'b0010);
                        state_d        = (op6 == OpAddi) ? StWb : StMem;
                    end
                    OpBeq: begin
                        bus.ALUControl = alu(4'b0110);
                        bus.PCSrc      = 1'b1;
                        bus.PCWrite    = bus.In_Is0;
                        bus.InstrDone  = 1'b1;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                bus.MemRead  = (op6 == OpLw);
                bus.MemWrite = (op6 != OpLw);
                if (bus.In_MemReady) begin
                    bus.InstrDone = (op6 != OpLw);
                    state_d       = (op6 == OpLw) ? StWb : StFetch;
                end else if (timeout) begin
                    // Abort the stuck access without committing the store.
                    bus.MemWrite = 1'b0;
                    bus.BusError = 1'b1;
                    state_d      = StFetch;
                end
            end
            StWb: begin
                bus.RegWrite  = 1'b1;
                bus.RegDst    = (op6 == OpRtype);
                bus.MemToReg  = (op6 == OpLw);
                bus.InstrDone = 1'b1;
                state_d       = StFetch;
            end
            StJump: begin
                bus.JumpPC    = 1'b1;
                bus.PCWrite   = 1'b1;
                bus.InstrDone = 1'b1;
                state_d       = StFetch;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || timeout) begin
            cnt_d = '0;
        end else if (mem_wait && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            opcode_q <= '0;
            funct_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                opcode_q <= bus.In_Opcode;
                funct_q  <= bus.In_Funct;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-cycle expected output vectors are queued by the stimulus
// and compared by negedge monitors for a MEM_TIMEOUT=4 and a MEM_TIMEOUT=0 instance.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_controller_if #(.OPCODE_W(6), .FUNCT_W(6), .ALUCTL_W(4)) bus ();
    multicycle_controller_if #(.OPCODE_W(6), .FUNCT_W(6), .ALUCTL_W(4)) bus0 ();

    multicycle_controller #(.OPCODE_W(6), .FUNCT_W(6), .ALUCTL_W(4), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    multicycle_controller #(.OPCODE_W(6), .FUNCT_W(6), .ALUCTL_W(4), .MEM_TIMEOUT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    assign bus0.In_Opcode   = bus.In_Opcode;
    assign bus0.In_Funct    = bus.In_Funct;
    assign bus0.In_Is0      = bus.In_Is0;
    assign bus0.In_MemReady = bus.In_MemReady;

    // Vector layout: RegDst RegWrite ALUSrc ALUControl[3:0] MemWrite MemRead MemToReg
    //                PCSrc JumpPC PCWrite IRWrite InstrDone IllegalOp BusError
    localparam logic [16:0] MRegDst   = 17'h10000;
    localparam logic [16:0] MRegWrite = 17'h08000;
    localparam logic [16:0] MAluSrc   = 17'h04000;
    localparam logic [16:0] MMemWrite = 17'h00200;
    localparam logic [16:0] MMemRead  = 17'h00100;
    localparam logic [16:0] MMemToReg = 17'h00080;
    localparam logic [16:0] MPcSrc    = 17'h00040;
    localparam logic [16:0] MJumpPc   = 17'h00020;
    localparam logic [16:0] MPcWrite  = 17'h00010;
    localparam logic [16:0] MIrWrite  = 17'h00008;
    localparam logic [16:0] MDone     = 17'h00004;
    localparam logic [16:0] MIllegal  = 17'h00002;
    localparam logic [16:0] MBusErr   = 17'h00001;
    localparam logic [16:0] Alu0 = 17'h00000;
    localparam logic [16:0] Alu1 = 17'h00400;
    localparam logic [16:0] Alu2 = 17'h00800;
    localparam logic [16:0] Alu6 = 17'h01800;
    localparam logic [16:0] Alu7 = 17'h01C00;
    localparam logic [16:0] F0   = MMemRead | Alu2;
    localparam logic [16:0] F1   = MMemRead | Alu2 | MIrWrite | MPcWrite;
    localparam logic [16:0] EMem = MAluSrc | Alu2;
    localparam logic [16:0] WbR  = MRegWrite | MRegDst | MDone;

    typedef struct {
        string       name;
        logic [16:0] v;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [16:0] got, got0;
    assign got  = {bus.RegDst, bus.RegWrite, bus.ALUSrc, bus.ALUControl, bus.MemWrite,
                   bus.MemRead, bus.MemToReg, bus.PCSrc, bus.JumpPC, bus.PCWrite,
                   bus.IRWrite, bus.InstrDone, bus.IllegalOp, bus.BusError};
    assign got0 = {bus0.RegDst, bus0.RegWrite, bus0.ALUSrc, bus0.ALUControl, bus0.MemWrite,
                   bus0.MemRead, bus0.MemToReg, bus0.PCSrc, bus0.JumpPC, bus0.PCWrite,
                   bus0.IRWrite, bus0.InstrDone, bus0.IllegalOp, bus0.BusError};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (got !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %05h expected %05h", e.name, got, e.v);
            end
        end
    end

    always @(negedge clk) begin
        if (q0.size() > 0) begin
            exp_t e;
            e = q0.pop_front();
            n_checks++;
            if (got0 !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %05h expected %05h", e.name, got0, e.v);
            end
        end
    end

    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                       input logic is0, input logic [16:0] ev, input string nm);
        exp_t e;
        bus.In_Opcode   = op;
        bus.In_Funct    = fn;
        bus.In_MemReady = rdy;
        bus.In_Is0      = is0;
        e.name = nm;
        e.v    = ev;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string nm);
        cyc(6'h00, 6'h00, 1'b1, 1'b0, F1, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        bus.In_Opcode = '0; bus.In_Funct = '0; bus.In_MemReady = 1'b0; bus.In_Is0 = 1'b0;
        @(posedge clk);
        #1;
        cyc(6'h00, 6'h00, 1'b1, 1'b0, '0, "reset");
        rst_n = 1'b1;
        cyc(6'h00, 6'h00, 1'b1, 1'b0, '0, "idle");

        // R-type add, slt, and
        fetch("add_f");
        cyc(6'h00, 6'h20, 1'b1, 1'b0, '0, "add_d");
        cyc(6'h00, 6'h00, 1'b1, 1'b0, Alu2, "add_e");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, WbR, "add_wb");
        fetch("slt_f");
        cyc(6'h00, 6'h2A, 1'b0, 1'b0, '0, "slt_d");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, Alu7, "slt_e");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, WbR, "slt_wb");
        fetch("and_f");
        cyc(6'h00, 6'h24, 1'b0, 1'b0, '0, "and_d");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, Alu0, "and_e");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, WbR, "and_wb");
        fetch("or_f");
        cyc(6'h00, 6'h25, 1'b0, 1'b0, '0, "or_d");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, Alu1, "or_e");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, WbR, "or_wb");

        // lw with three wait cycles in MEM
        fetch("lw_f");
        cyc(6'h23, 6'h00, 1'b0, 1'b0, '0, "lw_d");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, EMem, "lw_e");
        for (int i = 0; i < 3; i++) cyc(6'h00, 6'h00, 1'b0, 1'b0, MMemRead, "lw_mem_wait");
        cyc(6'h00, 6'h00, 1'b1, 1'b0, MMemRead, "lw_mem_rdy");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, MRegWrite | MMemToReg | MDone, "lw_wb");

        // sw, addi
        fetch("sw_f");
        cyc(6'h2B, 6'h00, 1'b0, 1'b0, '0, "sw_d");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, EMem, "sw_e");
        cyc(6'h00, 6'h00, 1'b1, 1'b0, MMemWrite | MDone, "sw_mem");
        fetch("addi_f");
        cyc(6'h08, 6'h00, 1'b0, 1'b0, '0, "addi_d");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, EMem, "addi_e");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, MRegWrite | MDone, "addi_wb");

        // beq taken / not taken
        fetch("beq1_f");
        cyc(6'h04, 6'h00, 1'b0, 1'b0, '0, "beq1_d");
        cyc(6'h00, 6'h00, 1'b0, 1'b1, Alu6 | MPcSrc | MPcWrite | MDone, "beq1_e");
        fetch("beq0_f");
        cyc(6'h04, 6'h00, 1'b0, 1'b0, '0, "beq0_d");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, Alu6 | MPcSrc | MDone, "beq0_e");

        // j
        fetch("j_f");
        cyc(6'h02, 6'h00, 1'b0, 1'b0, '0, "j_d");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, MJumpPc | MPcWrite | MDone, "j_jump");

        // Illegal opcode and illegal funct
        fetch("ill_op_f");
        cyc(6'h3F, 6'h00, 1'b0, 1'b0, MIllegal, "ill_op_d");
        fetch("ill_fn_f");
        cyc(6'h00, 6'h07, 1'b0, 1'b0, '0, "ill_fn_d");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, MIllegal, "ill_fn_e");

        // FETCH timeout on cycle 5, then ready on cycle 5 wins
        for (int i = 0; i < 4; i++) cyc(6'h00, 6'h00, 1'b0, 1'b0, F0, "to_f_wait");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, F0 | MBusErr, "to_f_buserr");
        for (int i = 0; i < 4; i++) cyc(6'h00, 6'h00, 1'b0, 1'b0, F0, "to_f_wait2");
        cyc(6'h00, 6'h00, 1'b1, 1'b0, F1, "to_f_ready_wins");
        cyc(6'h08, 6'h00, 1'b0, 1'b0, '0, "to_addi_d");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, EMem, "to_addi_e");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, MRegWrite | MDone, "to_addi_wb");

        // MEM timeout on a store: write suppressed on the abort cycle
        fetch("to_sw_f");
        cyc(6'h2B, 6'h00, 1'b0, 1'b0, '0, "to_sw_d");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, EMem, "to_sw_e");
        for (int i = 0; i < 4; i++) cyc(6'h00, 6'h00, 1'b0, 1'b0, MMemWrite, "to_sw_wait");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, MBusErr, "to_sw_buserr");

        // Async reset in the middle of a store's MEM phase
        fetch("rst_sw_f");
        cyc(6'h2B, 6'h00, 1'b0, 1'b0, '0, "rst_sw_d");
        cyc(6'h00, 6'h00, 1'b0, 1'b0, EMem, "rst_sw_e");
        e.name = "rst_mid_async";
        e.v    = '0;
        q.push_back(e);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc(6'h00, 6'h00, 1'b1, 1'b0, '0, "rst_hold");
        rst_n = 1'b1;
        cyc(6'h00, 6'h00, 1'b0, 1'b0, '0, "rst_idle");

        // Stuck FETCH: MEM_TIMEOUT=4 aborts every 5th cycle, MEM_TIMEOUT=0 never does
        for (int i = 0; i < 20; i++) begin
            e.name = "nto_wait";
            e.v    = F0;
            q0.push_back(e);
            cyc(6'h00, 6'h00, 1'b0, 1'b0, (i % 5 == 4) ? (F0 | MBusErr) : F0, "to_repeat");
        end

        for (int i = 0; i < 5 && (q.size() > 0 || q0.size() > 0); i++) @(posedge clk);
        if (q.size() > 0 || q0.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size() + q0.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
